// File: rtl/ps2_rx_frame.sv
// ============================================================================
// ps2_rx_frame : host-side PS/2 receiver (filter, sync, 11-bit frame check)
// Optional 4-entry byte FIFO with PS2RX_FIFO_EN.      Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  input  logic       i_rx_en,
`ifdef PS2RX_FIFO_EN
  input  logic       i_pop,
  output logic       o_overflow,
`endif
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam logic [7:0]  c_filt_last = 8'(FILTER_LEN - 1);
  localparam logic [16:0] c_tmo_last  = 17'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  logic        r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic        r_filt_clk, r_filt_d;
  logic [7:0]  r_filt_cnt;
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_bitcnt, w_bitcnt_nxt;
  logic [9:0]  r_sr, w_sr_nxt;
  logic [16:0] r_tmo, w_tmo_nxt;
  logic        w_strobe, w_bit, w_tmo_hit;
  logic        w_good, w_perr, w_ferr;

  // Synchronisers idle high; the filtered clock only follows a run of equal samples
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt_clk <= 1'b1;
      r_filt_d   <= 1'b1;
      r_filt_cnt <= 8'd0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_filt_d <= r_filt_clk;
      if (r_clk_s2 == r_filt_clk) begin
        r_filt_cnt <= 8'd0;
      end else if (r_filt_cnt == c_filt_last) begin
        r_filt_cnt <= 8'd0;
        r_filt_clk <= ~r_filt_clk;
      end else begin
        r_filt_cnt <= r_filt_cnt + 8'd1;
      end
    end
  end

  assign w_strobe  = r_filt_d & ~r_filt_clk;
  assign w_bit     = r_dat_s2;
  assign w_tmo_hit = (r_tmo == c_tmo_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_bitcnt <= 4'd0;
      r_sr     <= 10'd0;
      r_tmo    <= 17'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_sr     <= w_sr_nxt;
      r_tmo    <= w_tmo_nxt;
    end
  end

  // Priority in SHIFT: RxEn drop, then timeout, then strobe
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_sr_nxt     = r_sr;
    w_tmo_nxt    = r_tmo;
    w_good       = 1'b0;
    w_perr       = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tmo_nxt = 17'd0;
        if (i_rx_en && w_strobe && !w_bit) begin
          w_state_nxt  = S_SHIFT;
          w_bitcnt_nxt = 4'd0;
        end
      end
      S_SHIFT: begin
        if (!i_rx_en) begin
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
          w_ferr      = 1'b1;
        end else if (w_strobe) begin
          w_sr_nxt     = {w_bit, r_sr[9:1]};
          w_tmo_nxt    = 17'd0;
          w_bitcnt_nxt = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd9) begin
            w_state_nxt = S_CHECK;
          end
        end else begin
          w_tmo_nxt = r_tmo + 17'd1;
        end
      end
      S_CHECK: begin
        w_state_nxt = S_IDLE;
        if (i_rx_en) begin
          if (!r_sr[9]) begin
            w_ferr = 1'b1;
          end else if (!(^r_sr[8:0])) begin
            w_perr = 1'b1;
          end else begin
            w_good = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  logic r_perr, r_ferr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_perr <= w_perr;
      r_ferr <= w_ferr;
    end
  end

  assign o_parity_err = r_perr;
  assign o_frame_err  = r_ferr;
  assign o_busy       = (r_state != S_IDLE);

`ifdef PS2RX_FIFO_EN
  logic [7:0] r_fifo [0:3];
  logic [1:0] r_wr, r_rd;
  logic [2:0] r_cnt;
  logic       r_ovf;
  logic       w_pop, w_push, w_full;

  assign w_pop  = i_pop && (r_cnt != 3'd0);
  assign w_full = (r_cnt == 3'd4);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_push = w_good && (!w_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_fifo[i] <= 8'h00;
      end
      r_wr  <= 2'd0;
      r_rd  <= 2'd0;
      r_cnt <= 3'd0;
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_good && w_full && !w_pop;
      if (w_push) begin
        r_fifo[r_wr] <= r_sr[7:0];
        r_wr         <= r_wr + 2'd1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 2'd1;
      end
      r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  assign o_valid    = (r_cnt != 3'd0);
  assign o_data     = o_valid ? r_fifo[r_rd] : 8'h00;
  assign o_overflow = r_ovf;
`else
  logic [7:0] r_data;
  logic       r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_good;
      if (w_good) begin
        r_data <= r_sr[7:0];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_frame.sv
// ============================================================================
// tb_ps2_rx_frame : scoreboard bench for ps2_rx_frame (scaled PS/2 bit rate)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_rx_frame;

  localparam int FILT = 8;
  localparam int TMO  = 3000;
  localparam int HALF = 40;
  localparam int LEAD = 20;
  // falling edge -> sync (2) -> filter (FILT) -> strobe cycle -> CHECK -> output
  localparam int LAT  = FILT + 4;

  localparam logic [2:0] K_VALID = 3'd1;
  localparam logic [2:0] K_PERR  = 3'd2;
  localparam logic [2:0] K_FERR  = 3'd3;
  localparam logic [2:0] K_MULTI = 3'd4;
  localparam logic [2:0] K_OVF   = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [7:0]  data;
    logic [31:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] data;
  logic       valid, perr, ferr, busy;
`ifdef PS2RX_FIFO_EN
  logic       pop = 1'b0;
  logic       ovf;
`endif

  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  last_fall = 0;
  bit  busy_seen = 1'b0;
  bit  auto_pop = 1'b1;
  bit  prev_valid = 1'b0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  ps2_rx_frame #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .i_rx_en      (rx_en),
`ifdef PS2RX_FIFO_EN
    .i_pop        (pop),
    .o_overflow   (ovf),
`endif
    .o_data       (data),
    .o_valid      (valid),
    .o_parity_err (perr),
    .o_frame_err  (ferr),
    .o_busy       (busy)
  );

  always #10 clk = ~clk;

  // One clock step; output events are logged for the scoreboard
  task automatic tick();
    logic vevt;
    int   nst;
    @(posedge clk);
    #1;
    cyc++;
`ifdef PS2RX_FIFO_EN
    vevt = valid && !prev_valid;
    prev_valid = valid;
`else
    vevt = valid;
`endif
    nst = int'(vevt) + int'(perr) + int'(ferr);
    if (busy) busy_seen = 1'b1;
    if (nst > 1)    obs_q.push_back(ev_t'{K_MULTI, 8'h00, 32'(cyc)});
    else if (vevt)  obs_q.push_back(ev_t'{K_VALID, data, 32'(cyc)});
    else if (perr)  obs_q.push_back(ev_t'{K_PERR, 8'h00, 32'(cyc)});
    else if (ferr)  obs_q.push_back(ev_t'{K_FERR, 8'h00, 32'(cyc)});
`ifdef PS2RX_FIFO_EN
    if (ovf) obs_q.push_back(ev_t'{K_OVF, 8'h00, 32'(cyc)});
    if (auto_pop) pop = valid;
`endif
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (LEAD) tick();
    ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (HALF) tick();
    ps2_clk = 1'b1;
    repeat (HALF - LEAD) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_ok, input logic stop,
                            output int t_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par_ok ? ~^d : ^d);
    send_bit(stop);
    t_stop = last_fall;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) tick();
    n_chk++;
    if ({valid, perr, ferr, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got v/p/f/b=%b, want 0000", {valid, perr, ferr, busy});
    end
    n_chk++;
    if (data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got %h, want 00", data);
    end
    rst_n = 1'b1;
    repeat (20) tick();
    n_chk++;
    if (busy !== 1'b0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b events=%0d, want busy=0 events=0", busy, obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_good_frame();
    int t;
    ev_t e, o;
    send_frame(8'hFA, 1'b1, 1'b1, t);
    exp_q.push_back(ev_t'{K_VALID, 8'hFA, 32'(t + LAT)});
    repeat (30) tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL good_evt: got no event, want kind=%0d data=%h cyc=%0d", e.kind, e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL good_evt: got kind=%0d data=%h cyc=%0d, want kind=%0d data=%h cyc=%0d",
                   o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL good_after: got extra=%0d busy=%b, want 0 and 0", obs_q.size(), busy);
    end
    obs_q.delete();
  endtask

  task automatic test_parity_err();
    int t;
    ev_t e, o;
    send_frame(8'hAA, 1'b0, 1'b1, t);
    exp_q.push_back(ev_t'{K_PERR, 8'h00, 32'(t + LAT)});
    repeat (30) tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL parity_evt: got no event, want kind=%0d cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL parity_evt: got kind=%0d data=%h cyc=%0d, want kind=%0d cyc=%0d",
                   o.kind, o.data, o.cyc, e.kind, e.cyc);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL parity_extra: got %0d extra events, want 0", obs_q.size());
    end
    obs_q.delete();
`ifndef PS2RX_FIFO_EN
    n_chk++;
    if (data !== 8'hFA) begin
      n_fail++;
      $display("FAIL parity_hold: got data=%h, want FA", data);
    end
`endif
  endtask

  task automatic test_frame_err();
    int t;
    ev_t e, o;
    send_frame(8'h55, 1'b1, 1'b0, t);
    exp_q.push_back(ev_t'{K_FERR, 8'h00, 32'(t + LAT)});
    repeat (30) tick();
    // Short low glitch on an idle bus must not start a frame
    busy_seen = 1'b0;
    ps2_clk = 1'b0;
    repeat (3) tick();
    ps2_clk = 1'b1;
    repeat (40) tick();
    n_chk++;
    if (busy_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy: got busy=1 during glitch, want 0");
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL frame_evt: got no event, want kind=%0d cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL frame_evt: got kind=%0d data=%h cyc=%0d, want kind=%0d cyc=%0d",
                   o.kind, o.data, o.cyc, e.kind, e.cyc);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_extra: got %0d extra events, want 0", obs_q.size());
    end
    obs_q.delete();
`ifndef PS2RX_FIFO_EN
    n_chk++;
    if (data !== 8'hFA) begin
      n_fail++;
      $display("FAIL frame_hold: got data=%h, want FA", data);
    end
`endif
  endtask

  task automatic test_timeout();
    int t;
    logic [7:0] d;
    ev_t e, o;
    d = 8'h0B;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(d[i]);
    exp_q.push_back(ev_t'{K_FERR, 8'h00, 32'(last_fall + FILT + 3 + TMO)});
    repeat (TMO + 40) tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: got busy=%b, want 0", busy);
    end
    send_frame(8'h00, 1'b1, 1'b1, t);
    exp_q.push_back(ev_t'{K_VALID, 8'h00, 32'(t + LAT)});
    repeat (30) tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL timeout_evt: got no event, want kind=%0d data=%h cyc=%0d", e.kind, e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL timeout_evt: got kind=%0d data=%h cyc=%0d, want kind=%0d data=%h cyc=%0d",
                   o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_extra: got %0d extra events, want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_rx_en();
    int t;
    logic [7:0] d;
    ev_t e, o;
    d = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(d[i]);
    rx_en = 1'b0;
    tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rxen_abort: got busy=%b one cycle after RxEn=0, want 0", busy);
    end
    repeat (20) tick();
    rx_en = 1'b1;
    repeat (10) tick();
    send_frame(8'h12, 1'b1, 1'b1, t);
    exp_q.push_back(ev_t'{K_VALID, 8'h12, 32'(t + LAT)});
    repeat (30) tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL rxen_evt: got no event, want kind=%0d data=%h cyc=%0d", e.kind, e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL rxen_evt: got kind=%0d data=%h cyc=%0d, want kind=%0d data=%h cyc=%0d",
                   o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL rxen_extra: got %0d extra events, want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h77;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy: got busy=%b before reset, want 1", busy);
    end
    rst_n = 1'b0;
    #3;
    n_chk++;
    if ({valid, perr, ferr, busy} !== 4'b0000 || data !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_out: got v/p/f/b=%b data=%h, want 0000 and 00",
               {valid, perr, ferr, busy}, data);
    end
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    n_chk++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_after: got events=%0d busy=%b, want 0 and 0", obs_q.size(), busy);
    end
    obs_q.delete();
  endtask

`ifdef PS2RX_FIFO_EN
  task automatic test_fifo();
    int t;
    ev_t e, o;
    auto_pop = 1'b0;
    pop = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b1, t);
      if (i == 1) exp_q.push_back(ev_t'{K_VALID, 8'h01, 32'(t + LAT)});
      if (i == 5) exp_q.push_back(ev_t'{K_OVF, 8'h00, 32'(t + LAT)});
    end
    repeat (30) tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL fifo_evt: got no event, want kind=%0d cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL fifo_evt: got kind=%0d data=%h cyc=%0d, want kind=%0d data=%h cyc=%0d",
                   o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end
      end
    end
    obs_q.delete();
    for (int i = 1; i <= 4; i++) begin
      n_chk++;
      if (valid !== 1'b1 || data !== 8'(i)) begin
        n_fail++;
        $display("FAIL fifo_pop: got valid=%b data=%h, want 1 and %h", valid, data, 8'(i));
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
      tick();
    end
    n_chk++;
    if (valid !== 1'b0 || data !== 8'h00) begin
      n_fail++;
      $display("FAIL fifo_empty: got valid=%b data=%h, want 0 and 00", valid, data);
    end
    obs_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_timeout();
    test_rx_en();
    test_reset_mid_frame();
`ifdef PS2RX_FIFO_EN
    test_fifo();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
